// File: rtl/axi_wr_target_sched.sv
// Write-beat scheduler: routes one AXI write beat to the cmd FIFO, IRAM or WRAM and
// arbitrates the WRAM port with engine write-back. Optional FIFO-full timeout: WR_TIMEOUT_EN.
module axi_wr_target_sched #(
    parameter int unsigned ADDR_W      = 11,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned IRAM_AW     = 9,
    parameter int unsigned WRAM_AW     = 9,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               axi_wr_vld_i,
    input  logic [ADDR_W-1:0]  axi_wr_addr_i,
    input  logic [DATA_W-1:0]  axi_wr_data_i,
    input  logic [DATA_W-1:0]  axi_wr_strb_i,
    input  logic [1:0]         axi_wr_region_i,
    output logic               fifo_wr_done_o,
    output logic               fifo_err_o,
    output logic               iram_wr_done_o,
    output logic               wram_wr_done_o,
    output logic               fifo_push_o,
    output logic [DATA_W-1:0]  fifo_wdata_o,
    input  logic               fifo_full_i,
    output logic               iram_we_o,
    output logic [IRAM_AW-1:0] iram_addr_o,
    output logic [DATA_W-1:0]  iram_wdata_o,
    output logic [DATA_W-1:0]  iram_wmask_o,
    input  logic               iram_busy_i,
    input  logic               eng_wr_req_i,
    input  logic [WRAM_AW-1:0] eng_wr_addr_i,
    input  logic [DATA_W-1:0]  eng_wr_data_i,
    output logic               eng_wr_gnt_o,
    output logic               wram_we_o,
    output logic [WRAM_AW-1:0] wram_addr_o,
    output logic [DATA_W-1:0]  wram_wdata_o,
    output logic [DATA_W-1:0]  wram_wmask_o,
    output logic               sched_ovf_o
);

    typedef enum logic [2:0] {StIdle, StFifoWait, StIramWait, StWramWait, StDone} state_e;

    state_e              state_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   data_q;
    logic [DATA_W-1:0]   strb_q;
    logic                bad_q;
    logic                prefer_eng_q;
    logic                axi_gnt_q;
    logic                fifo_push_q;
    logic                iram_we_q;
    logic                wram_we_q;
    logic                eng_wr_gnt_q;
    logic                fifo_wr_done_q;
    logic                fifo_err_q;
    logic                iram_wr_done_q;
    logic                wram_wr_done_q;
    logic                sched_ovf_q;
    logic [WRAM_AW-1:0]  wram_addr_q;
    logic [DATA_W-1:0]   wram_wdata_q;
    logic [DATA_W-1:0]   wram_wmask_q;
`ifdef WR_TIMEOUT_EN
    logic [7:0]          tmo_cnt_q;
`endif

    logic                axi_wram_req;
    logic                eng_req_eff;
    logic                gnt_axi;
    logic                gnt_eng;
    logic [ADDR_W-1:0]   axi_addr_src;
    logic [DATA_W-1:0]   axi_data_src;
    logic [DATA_W-1:0]   axi_strb_src;

    // Strobes are registered, so the grant is decided one edge early: a beat accepted in IDLE
    // already competes, and an engine request being granted this cycle is not granted again.
    always_comb begin
        axi_wram_req = 1'b0;
        if (state_q == StIdle) begin
            axi_wram_req = axi_wr_vld_i && (axi_wr_region_i == 2'd2);
        end else if (state_q == StWramWait) begin
            axi_wram_req = !axi_gnt_q;
        end
        axi_addr_src = (state_q == StIdle) ? axi_wr_addr_i : addr_q;
        axi_data_src = (state_q == StIdle) ? axi_wr_data_i : data_q;
        axi_strb_src = (state_q == StIdle) ? axi_wr_strb_i : strb_q;
        eng_req_eff  = eng_wr_req_i && !eng_wr_gnt_q;
        gnt_axi      = axi_wram_req && (!eng_req_eff || !prefer_eng_q);
        gnt_eng      = eng_req_eff && !gnt_axi;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q        <= StIdle;
            addr_q         <= '0;
            data_q         <= '0;
            strb_q         <= '0;
            bad_q          <= 1'b0;
            prefer_eng_q   <= 1'b0;
            axi_gnt_q      <= 1'b0;
            fifo_push_q    <= 1'b0;
            iram_we_q      <= 1'b0;
            wram_we_q      <= 1'b0;
            eng_wr_gnt_q   <= 1'b0;
            fifo_wr_done_q <= 1'b0;
            fifo_err_q     <= 1'b0;
            iram_wr_done_q <= 1'b0;
            wram_wr_done_q <= 1'b0;
            sched_ovf_q    <= 1'b0;
            wram_addr_q    <= '0;
            wram_wdata_q   <= '0;
            wram_wmask_q   <= '0;
`ifdef WR_TIMEOUT_EN
            tmo_cnt_q      <= '0;
`endif
        end else begin
            fifo_push_q    <= 1'b0;
            iram_we_q      <= 1'b0;
            wram_we_q      <= 1'b0;
            eng_wr_gnt_q   <= 1'b0;
            axi_gnt_q      <= 1'b0;
            fifo_wr_done_q <= 1'b0;
            fifo_err_q     <= 1'b0;
            iram_wr_done_q <= 1'b0;
            wram_wr_done_q <= 1'b0;

            if (axi_wr_vld_i && (state_q != StIdle)) begin
                sched_ovf_q <= 1'b1;
            end

            if (gnt_axi) begin
                wram_we_q    <= 1'b1;
                axi_gnt_q    <= 1'b1;
                prefer_eng_q <= 1'b1;
                wram_addr_q  <= axi_addr_src[WRAM_AW+1:2];
                wram_wdata_q <= axi_data_src;
                wram_wmask_q <= axi_strb_src;
            end else if (gnt_eng) begin
                wram_we_q    <= 1'b1;
                eng_wr_gnt_q <= 1'b1;
                prefer_eng_q <= 1'b0;
                wram_addr_q  <= eng_wr_addr_i;
                wram_wdata_q <= eng_wr_data_i;
                wram_wmask_q <= '1;
            end

            unique case (state_q)
                StIdle: begin
                    if (axi_wr_vld_i) begin
                        addr_q <= axi_wr_addr_i;
                        data_q <= axi_wr_data_i;
                        strb_q <= axi_wr_strb_i;
                        bad_q  <= (axi_wr_region_i == 2'd3);
                        unique case (axi_wr_region_i)
                            2'd0: begin
                                fifo_push_q <= !fifo_full_i;
                                state_q     <= StFifoWait;
`ifdef WR_TIMEOUT_EN
                                tmo_cnt_q   <= '0;
`endif
                            end
                            2'd1: begin
                                iram_we_q <= !iram_busy_i;
                                state_q   <= StIramWait;
                            end
                            2'd2: state_q <= StWramWait;
                            2'd3: state_q <= StDone;
                        endcase
                    end
                end
                StFifoWait: begin
                    if (fifo_push_q) begin
                        fifo_wr_done_q <= 1'b1;
                        state_q        <= StDone;
                    end else if (!fifo_full_i) begin
                        fifo_push_q <= 1'b1;
                    end
`ifdef WR_TIMEOUT_EN
                    else if (tmo_cnt_q == 8'(TIMEOUT_CYC - 1)) begin
                        fifo_wr_done_q <= 1'b1;
                        fifo_err_q     <= 1'b1;
                        state_q        <= StDone;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 8'd1;
                    end
`endif
                end
                StIramWait: begin
                    if (iram_we_q) begin
                        iram_wr_done_q <= 1'b1;
                        state_q        <= StDone;
                    end else if (!iram_busy_i) begin
                        iram_we_q <= 1'b1;
                    end
                end
                StWramWait: begin
                    if (axi_gnt_q) begin
                        wram_wr_done_q <= 1'b1;
                        state_q        <= StDone;
                    end
                end
                StDone: begin
                    // An invalid-region beat has no target cycle, so it spends an extra cycle
                    // here to issue its error completion.
                    if (bad_q) begin
                        fifo_wr_done_q <= 1'b1;
                        fifo_err_q     <= 1'b1;
                        bad_q          <= 1'b0;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    logic unused_bits;
    assign unused_bits = ^{addr_q[1:0], 8'(TIMEOUT_CYC)};

    assign fifo_wr_done_o = fifo_wr_done_q;
    assign fifo_err_o     = fifo_err_q;
    assign iram_wr_done_o = iram_wr_done_q;
    assign wram_wr_done_o = wram_wr_done_q;
    assign fifo_push_o    = fifo_push_q;
    assign fifo_wdata_o   = data_q;
    assign iram_we_o      = iram_we_q;
    assign iram_addr_o    = addr_q[IRAM_AW+1:2];
    assign iram_wdata_o   = data_q;
    assign iram_wmask_o   = strb_q;
    assign eng_wr_gnt_o   = eng_wr_gnt_q;
    assign wram_we_o      = wram_we_q;
    assign wram_addr_o    = wram_addr_q;
    assign wram_wdata_o   = wram_wdata_q;
    assign wram_wmask_o   = wram_wmask_q;
    assign sched_ovf_o    = sched_ovf_q;

endmodule
